// File: rtl/maze_nav_ctrl_if.sv
// Bundle of the maze navigation controller's signals: keys, frame sync, level
// size, wall-map read port and the status outputs.
//   master : the navigation controller (drives o_* signals)
//   slave  : the surrounding game (keys, renderer, wall map, display)
// The parameters must match those of the maze_nav_ctrl instance using it.
interface maze_nav_ctrl_if #(
    parameter int MAX_COL    = 64,
    parameter int MAX_ROW    = 48,
    parameter int NUM_LEVELS = 3,
    parameter int CNT_W      = 16
);
    localparam int COL_W  = $clog2(MAX_COL);
    localparam int ROW_W  = $clog2(MAX_ROW);
    localparam int LV_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int ADDR_W = $clog2(MAX_COL * MAX_ROW);

    logic              i_Start;
    logic              i_KeyValid;
    logic [3:0]        i_KeyDir;
    logic              i_FrameDone;
    logic [COL_W-1:0]  i_LvCols;
    logic [ROW_W-1:0]  i_LvRows;
    logic [ADDR_W-1:0] o_MapAddr;
    logic              o_MapRd;
    logic              i_MapWall;
    logic [LV_W-1:0]   o_Level;
    logic [COL_W-1:0]  o_PosX;
    logic [ROW_W-1:0]  o_PosY;
    logic              o_Running;
    logic              o_Done;
    logic              o_Bump;
    logic [CNT_W-1:0]  o_MoveCnt;

    modport master (
        input  i_Start, i_KeyValid, i_KeyDir, i_FrameDone, i_LvCols, i_LvRows, i_MapWall,
        output o_MapAddr, o_MapRd, o_Level, o_PosX, o_PosY, o_Running, o_Done, o_Bump,
        output o_MoveCnt
    );

    modport slave (
        output i_Start, i_KeyValid, i_KeyDir, i_FrameDone, i_LvCols, i_LvRows, i_MapWall,
        input  o_MapAddr, o_MapRd, o_Level, o_PosX, o_PosY, o_Running, o_Done, o_Bump,
        input  o_MoveCnt
    );
endinterface

// File: rtl/maze_nav_ctrl.sv
// Maze-game navigation controller. Holds game state, level index and player
// position; each key move is vetted against an external wall map through a
// 1-cycle read port, and an accepted move only lands on a frame-done pulse.
// Ports:
//   i_Clk  clock
//   i_Rst  asynchronous reset, active-low
//   bus    maze_nav_ctrl_if.master: keys, frame-done, level size, wall-map
//          read port (o_MapAddr/o_MapRd -> i_MapWall next cycle), and the
//          status outputs (level, position, running, done, bump, move count)
module maze_nav_ctrl #(
    parameter int MAX_COL    = 64,
    parameter int MAX_ROW    = 48,
    parameter int NUM_LEVELS = 3,
    parameter int CNT_W      = 16
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    maze_nav_ctrl_if.master bus
);
    localparam int COL_W  = $clog2(MAX_COL);
    localparam int ROW_W  = $clog2(MAX_ROW);
    localparam int LV_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int ADDR_W = $clog2(MAX_COL * MAX_ROW);

    localparam logic signed [COL_W:0] ONE_X = 1;
    localparam logic signed [ROW_W:0] ONE_Y = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_KEY, S_CHECK, S_COMMIT, S_LV_CHECK, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LV_W-1:0]    level_q, level_d;
    logic [COL_W-1:0]   pos_x_q, pos_x_d;
    logic [ROW_W-1:0]   pos_y_q, pos_y_d;
    logic [COL_W-1:0]   tgt_x_q, tgt_x_d;
    logic [ROW_W-1:0]   tgt_y_q, tgt_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  map_addr_q, map_addr_d;
    logic               bump_q, bump_d;

    logic               map_rd;
    logic               key_hit;
    logic               outside;
    logic               goal;
    logic               last_level;
    logic signed [COL_W:0] tx;
    logic signed [ROW_W:0] ty;
    logic [ADDR_W-1:0]  addr_calc;

    // Target cell, one bit wider and signed so a step off the top/left edge shows as -1.
    always_comb begin
        tx = $signed({1'b0, pos_x_q});
        ty = $signed({1'b0, pos_y_q});
        if (bus.i_KeyDir[3])      tx = tx - ONE_X;
        else if (bus.i_KeyDir[2]) ty = ty - ONE_Y;
        else if (bus.i_KeyDir[1]) ty = ty + ONE_Y;
        else if (bus.i_KeyDir[0]) tx = tx + ONE_X;
    end

    assign key_hit   = bus.i_KeyValid && (bus.i_KeyDir != 4'b0000);
    assign outside   = tx[COL_W] || ty[ROW_W]
                    || (tx >= $signed({1'b0, bus.i_LvCols}))
                    || (ty >= $signed({1'b0, bus.i_LvRows}));
    assign addr_calc = ADDR_W'(ty[ROW_W-1:0]) * ADDR_W'(bus.i_LvCols)
                     + ADDR_W'(tx[COL_W-1:0]);
    assign goal       = (pos_x_q == bus.i_LvCols - COL_W'(2))
                     && (pos_y_q == bus.i_LvRows - ROW_W'(2));
    assign last_level = (level_q == LV_W'(NUM_LEVELS - 1));

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        cnt_d      = cnt_q;
        map_addr_d = map_addr_q;
        bump_d     = 1'b0;
        map_rd     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_Start) state_d = S_LOAD;
            end
            S_LOAD: begin
                pos_x_d = COL_W'(1);
                pos_y_d = ROW_W'(1);
                state_d = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                if (key_hit) begin
                    if (outside) begin
                        bump_d = 1'b1;
                    end else begin
                        // Read is issued this cycle so the wall bit arrives in CHECK.
                        map_rd     = 1'b1;
                        map_addr_d = addr_calc;
                        tgt_x_d    = tx[COL_W-1:0];
                        tgt_y_d    = ty[ROW_W-1:0];
                        state_d    = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (bus.i_MapWall) begin
                    bump_d  = 1'b1;
                    state_d = S_WAIT_KEY;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (bus.i_FrameDone) begin
                    pos_x_d = tgt_x_q;
                    pos_y_d = tgt_y_q;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    state_d = S_LV_CHECK;
                end
            end
            S_LV_CHECK: begin
                if (goal && last_level) begin
                    state_d = S_DONE;
                end else if (goal) begin
                    level_d = level_q + LV_W'(1);
                    state_d = S_LOAD;
                end else begin
                    state_d = S_WAIT_KEY;
                end
            end
            S_DONE: begin
                if (bus.i_Start) begin
                    level_d = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= S_IDLE;
            level_q    <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            cnt_q      <= '0;
            map_addr_q <= '0;
            bump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            cnt_q      <= cnt_d;
            map_addr_q <= map_addr_d;
            bump_q     <= bump_d;
        end
    end

    // The address is live in the request cycle and then held for the map's sake.
    assign bus.o_MapRd     = map_rd;
    assign bus.o_MapAddr   = map_rd ? addr_calc : map_addr_q;
    assign bus.o_Level     = level_q;
    assign bus.o_PosX      = pos_x_q;
    assign bus.o_PosY      = pos_y_q;
    assign bus.o_Running   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.o_Done      = (state_q == S_DONE);
    assign bus.o_Bump      = bump_q;
    assign bus.o_MoveCnt   = cnt_q;
endmodule
